fifo_nibble_tx: RTL and testbench
=================================

FIFO_NIBBLE_TX -- requirements
Module: fifo_nibble_tx

Interface
REQ-001: The block SHALL have parameter D_WIDTH, default 4, meaning the FIFO read-data width in bits.
REQ-002: The block SHALL have parameter CLKS_PER_BIT, default 4, range 2..255, meaning clk cycles per serial bit.
REQ-003: The block SHALL have parameter PARITY_EN, default 1, meaning an even-parity bit is inserted when 1.
REQ-004: The block SHALL have parameter RD_LAT, default 1, range 0..3, meaning clk cycles from the rinc pulse to valid rdata.
REQ-005: Port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-006: Port rst_n, input, 1; reset SHALL be asynchronous and active-low.
REQ-007: Port en, input, 1, transmit enable; new frames start only when high.
REQ-008: Port empty, input, 1, FIFO empty flag.
REQ-009: Port rdata, input, D_WIDTH, FIFO read data.
REQ-010: Port rinc, output, 1, FIFO pop strobe.
REQ-011: Port tx, output, 1, serial line; idle high.
REQ-012: Port busy, output, 1, high while a frame is in progress.
REQ-013: Port frame_done, output, 1, one-cycle pulse at frame end.

Function
REQ-014: All outputs SHALL be registered.
REQ-015: FSM states SHALL be IDLE, POP, WAIT, START, DATA, PARITY, STOP.
REQ-016: IDLE: if en=1 and empty=0 at a clk edge, the FSM SHALL enter POP; otherwise it stays in IDLE with tx=1.
REQ-017: POP SHALL last exactly one cycle with rinc=1; rinc SHALL be 0 in every other state.
REQ-018: WAIT SHALL last RD_LAT cycles (0 means skip WAIT); on exit, rdata SHALL be captured into a shift register and the FSM SHALL enter START.
REQ-019: START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-020: DATA SHALL drive the D_WIDTH captured bits LSB first, each for CLKS_PER_BIT cycles.
REQ-021: PARITY (PARITY_EN=1 only) SHALL drive the XOR of the captured bits for CLKS_PER_BIT cycles, making total ones even; with PARITY_EN=0 the FSM goes DATA->STOP.
REQ-022: STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; frame_done SHALL pulse in its last cycle; the next state SHALL be IDLE.
REQ-023: Frame length on tx SHALL be CLKS_PER_BIT*(D_WIDTH+2+PARITY_EN) cycles.
REQ-024: The bit counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and wrap to 0 at CLKS_PER_BIT-1.
REQ-025: busy SHALL be 1 in every state except IDLE.
REQ-026: Back-to-back frames: IDLE SHALL occupy at least one cycle between frames, so the stop-to-start gap is at least 1 clk.
REQ-027: en falling mid-frame SHALL NOT abort the frame; the FSM returns to IDLE and pops nothing further.
REQ-028: empty changes after POP SHALL NOT affect the frame in progress.
REQ-029: Exactly one rinc pulse SHALL occur per frame; no pop SHALL occur while empty=1.

Reset
REQ-030: On rst_n=0, regardless of clk, the FSM SHALL go to IDLE, with tx=1, rinc=0, busy=0, frame_done=0, and counters and the shift register cleared.
REQ-031: Reset mid-frame SHALL abandon the frame; the popped word is lost and is not re-popped.
REQ-032: After rst_n rises, the first pop SHALL occur no earlier than the second clk edge.

Verification
REQ-033: Defaults; rdata=4'b1011, empty=0, en=1 for one frame -> one rinc pulse; 2 cycles later tx=0,1,1,0,1,1,1, each held 4 cycles (28 total); frame_done once.
REQ-034: PARITY_EN=0, rdata=4'b0000 -> tx=0,0,0,0,0,1 over 24 cycles; no parity bit.
REQ-035: Three words queued with en held high -> 3 rinc pulses and 3 frames, each separated by 1 idle cycle of tx=1.
REQ-036: empty=1 with en=1 for 100 cycles -> rinc=0, tx=1, busy=0 throughout.
REQ-037: Deassert en during DATA -> the frame completes normally; no further rinc.
REQ-038: Assert rst_n=0 in the PARITY state -> tx=1 and busy=0 immediately, with no clk edge needed; after release with empty=0 the next frame is correct.

Source files
------------

// File: rtl/fifo_nibble_tx.sv
// Pops one word from a FIFO and serialises it on tx as start, LSB-first data,
// optional even parity and stop, each held CLKS_PER_BIT clk cycles.
module fifo_nibble_tx #(
   parameter int D_WIDTH      = 4,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1,
   parameter int RD_LAT       = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               empty,
   input  logic [D_WIDTH-1:0] rdata,
   output logic               rinc,
   output logic               tx,
   output logic               busy,
   output logic               frame_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(D_WIDTH - 1);
   localparam logic [1:0]    WAIT_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

   typedef enum logic [2:0] {
      IDLE, POP, WAIT, START, DATA, PARITY, STOP
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [BW-1:0]      bit_q, bit_d;
   logic [1:0]         wait_q, wait_d;
   logic [D_WIDTH-1:0] shreg_q, shreg_d;
   logic               par_q, par_d;
   logic               armed_q;
   logic               cnt_last;
   logic               tx_d, rinc_d, busy_d, done_d;

   assign cnt_last = (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      wait_d  = wait_q;
      shreg_d = shreg_q;
      par_d   = par_q;

      // One bit-time counter shared by every line-driving state.
      if (state_q inside {START, DATA, PARITY, STOP}) begin
         cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            // armed_q holds off the first pop until the second edge after reset.
            if (armed_q && en && !empty) begin
               state_d = POP;
            end
         end
         POP: begin
            wait_d = '0;
            if (RD_LAT == 0) begin
               shreg_d = rdata;
               par_d   = ^rdata;
               cnt_d   = '0;
               state_d = START;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (wait_q == WAIT_LAST) begin
               shreg_d = rdata;
               par_d   = ^rdata;
               cnt_d   = '0;
               state_d = START;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end
         START: begin
            if (cnt_last) begin
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (cnt_last) begin
               shreg_d = shreg_q >> 1;
               if (bit_q == BIT_LAST) begin
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         PARITY: begin
            if (cnt_last) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = 1'b1;
      endcase
      rinc_d = (state_d == POP);
      busy_d = (state_d != IDLE);
      done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         wait_q     <= '0;
         shreg_q    <= '0;
         par_q      <= 1'b0;
         armed_q    <= 1'b0;
         tx         <= 1'b1;
         rinc       <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         wait_q     <= wait_d;
         shreg_q    <= shreg_d;
         par_q      <= par_d;
         armed_q    <= 1'b1;
         tx         <= tx_d;
         rinc       <= rinc_d;
         busy       <= busy_d;
         frame_done <= done_d;
      end
   end

endmodule

// File: tb/tb_fifo_nibble_tx.sv
// Bench for fifo_nibble_tx: a parity/RD_LAT=1 instance fed by a registered FIFO
// model and a no-parity/RD_LAT=0 instance, checked against a bit-cell frame model.
module tb_fifo_nibble_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en0, empty0, rinc0, tx0, busy0, done0;
   logic [3:0] rdata0;
   logic       en1, empty1, rinc1, tx1, busy1, done1;
   logic [3:0] rdata1;
   logic       sel;
   logic       tx_s, rinc_s, busy_s, done_s;

   logic [3:0] fifo_q[$];
   logic [3:0] exp_q[$];
   int         checks = 0;
   int         failures = 0;
   int         pop_on_empty = 0;

   always #5 clk = ~clk;

   fifo_nibble_tx #(.D_WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .RD_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en0), .empty(empty0), .rdata(rdata0),
      .rinc(rinc0), .tx(tx0), .busy(busy0), .frame_done(done0)
   );

   fifo_nibble_tx #(.D_WIDTH(4), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .RD_LAT(0)) u_dut_np (
      .clk(clk), .rst_n(rst_n), .en(en1), .empty(empty1), .rdata(rdata1),
      .rinc(rinc1), .tx(tx1), .busy(busy1), .frame_done(done1)
   );

   assign tx_s   = sel ? tx1   : tx0;
   assign rinc_s = sel ? rinc1 : rinc0;
   assign busy_s = sel ? busy1 : busy0;
   assign done_s = sel ? done1 : done0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clk cycle, negedge to negedge; the FIFO models react to rinc at the edge.
   task automatic step();
      logic p0, p1;
      p0 = rinc0;
      p1 = rinc1;
      if (p0 && empty0) pop_on_empty++;
      if (p1 && empty1) pop_on_empty++;
      @(posedge clk);
      #1;
      if (p0 && fifo_q.size() > 0) rdata0 = fifo_q.pop_front();
      if (p1) empty1 = 1'b1;
      empty0 = (fifo_q.size() == 0);
      @(negedge clk);
   endtask

   task automatic push0(input logic [3:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
      empty0 = 1'b0;
   endtask

   task automatic push1(input logic [3:0] w);
      rdata1 = w;
      exp_q.push_back(w);
      empty1 = 1'b0;
   endtask

   // Waits for the pop, then compares every cycle against the ideal frame.
   task automatic check_frame(input logic s, input int drop_en_at, output int waited);
      logic       bits[$];
      logic [3:0] w;
      int         rdlat, n;
      sel    = s;
      waited = 0;
      #1;
      while (rinc_s !== 1'b1 && waited < 40) begin
         check_eq("idle_tx", tx_s, 1'b1);
         check_eq("idle_busy", busy_s, 1'b0);
         step();
         waited++;
      end
      check_eq("rinc_seen", rinc_s, 1'b1);
      if (rinc_s !== 1'b1 || exp_q.size() == 0) return;
      w     = exp_q.pop_front();
      rdlat = s ? 0 : 1;
      for (int i = 0; i < 1 + rdlat; i++) bits.push_back(1'b1);
      for (int c = 0; c < CPB; c++) bits.push_back(1'b0);
      for (int b = 0; b < 4; b++)
         for (int c = 0; c < CPB; c++) bits.push_back(w[b]);
      if (!s)
         for (int c = 0; c < CPB; c++) bits.push_back(^w);
      for (int c = 0; c < CPB; c++) bits.push_back(1'b1);
      n = bits.size();
      for (int i = 0; i < n; i++) begin
         if (i == drop_en_at) begin
            en0 = 1'b0;
            en1 = 1'b0;
         end
         check_eq($sformatf("tx[%0d] w=%0h", i, w), tx_s, bits[i]);
         check_eq($sformatf("busy[%0d]", i), busy_s, 1'b1);
         check_eq($sformatf("rinc[%0d]", i), rinc_s, (i == 0));
         check_eq($sformatf("done[%0d]", i), done_s, (i == n - 1));
         step();
      end
      check_eq("end_busy", busy_s, 1'b0);
      check_eq("end_tx", tx_s, 1'b1);
   endtask

   initial begin
      int         waited;
      int         bad;
      logic [3:0] w;
      sel    = 1'b0;
      rst_n  = 1'b0;
      en0    = 1'b0;
      en1    = 1'b0;
      empty0 = 1'b1;
      empty1 = 1'b1;
      rdata0 = 4'h0;
      rdata1 = 4'h0;
      @(negedge clk);
      step();
      step();
      check_eq("rst_tx", tx0, 1'b1);
      check_eq("rst_busy", busy0, 1'b0);
      check_eq("rst_rinc", rinc0, 1'b0);
      check_eq("rst_done", done0, 1'b0);
      check_eq("rst_tx_np", tx1, 1'b1);
      rst_n = 1'b1;

      // Directed 4'b1011 frame straight after reset release.
      push0(4'b1011);
      en0 = 1'b1;
      check_frame(1'b0, -1, waited);
      check_eq("first_pop_not_before_edge2", (waited >= 2), 1'b1);
      en0 = 1'b0;

      // Empty FIFO with en high: line stays idle.
      en0 = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if ({rinc0, tx0, busy0} !== 3'b010) bad++;
         step();
      end
      check_eq("empty_idle_cycles_bad", bad, 0);

      // Three queued words, back to back.
      for (int i = 0; i < 3; i++) push0(4'($urandom_range(0, 15)));
      check_frame(1'b0, -1, waited);
      check_frame(1'b0, -1, waited);
      check_eq("b2b_gap2", waited, 1);
      check_frame(1'b0, -1, waited);
      check_eq("b2b_gap3", waited, 1);
      en0 = 1'b0;

      // en dropped during DATA: frame completes, no further pop.
      push0(4'($urandom_range(0, 15)));
      push0(4'($urandom_range(0, 15)));
      en0 = 1'b1;
      check_frame(1'b0, 10, waited);
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (rinc0 !== 1'b0 || busy0 !== 1'b0) bad++;
         step();
      end
      check_eq("en_low_no_pop", bad, 0);
      en0 = 1'b1;
      check_frame(1'b0, -1, waited);
      en0 = 1'b0;

      // Random words with random idle gaps.
      for (int k = 0; k < 4; k++) begin
         push0(4'($urandom_range(0, 15)));
         en0 = 1'b1;
         check_frame(1'b0, -1, waited);
         en0 = 1'b0;
         for (int g = 0; g < int'($urandom_range(0, 5)); g++) step();
      end

      // No-parity, zero-latency instance: all-zero word then a random word.
      push1(4'b0000);
      en1 = 1'b1;
      check_frame(1'b1, -1, waited);
      push1(4'($urandom_range(0, 15)));
      check_frame(1'b1, -1, waited);
      en1 = 1'b0;
      sel = 1'b0;

      // Reset asserted in the parity cell.
      w = 4'($urandom_range(0, 15));
      push0(w);
      en0 = 1'b1;
      waited = 0;
      while (rinc0 !== 1'b1 && waited < 40) begin
         step();
         waited++;
      end
      check_eq("rst_case_rinc", rinc0, 1'b1);
      for (int i = 0; i < 23; i++) step();
      check_eq("parity_bit", tx0, ^w);
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_tx", tx0, 1'b1);
      check_eq("async_rst_busy", busy0, 1'b0);
      check_eq("async_rst_rinc", rinc0, 1'b0);
      check_eq("async_rst_done", done0, 1'b0);
      void'(exp_q.pop_front());
      step();
      step();
      push0(4'($urandom_range(0, 15)));
      rst_n = 1'b1;
      step();
      check_eq("no_pop_edge1", rinc0, 1'b0);
      check_frame(1'b0, -1, waited);
      en0 = 1'b0;

      check_eq("pop_on_empty", pop_on_empty, 0);
      check_eq("exp_q_drained", exp_q.size(), 0);
      check_eq("fifo_drained", fifo_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
